// File: rtl/alu_decode_pkg.sv
// Shared opcode/funct encodings, control enums and the registered control word.
// ILLEGAL_FLAG_EN: is_known() backs the optional illegal-encoding flag in the top.
package alu_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_PASSB} alu_op_e;
  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_RSVD} ext_op_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_BEQ, PC_JAL, PC_JR} pc_op_e;
  typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_PC4, SEL_RSVD} grf_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    pc_op_e     pc_op;
    logic       dm_we;
    logic       grf_we;
    logic [4:0] grf_waddr;
    grf_sel_e   grf_data_sel;
    logic       alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:       ALU_ADD,
    pc_op:        PC_PLUS4,
    dm_we:        1'b0,
    grf_we:       1'b0,
    grf_waddr:    5'd0,
    grf_data_sel: SEL_ALU,
    alu_src:      1'b0
  };

  function automatic logic is_known(input logic [31:0] word);
    logic [5:0] op;
    logic [5:0] fn;
    op = word[31:26];
    fn = word[5:0];
    case (op)
      OP_RTYPE: is_known = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_JR);
      OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_JAL: is_known = 1'b1;
      default: is_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_alu.sv
// 32-bit ALU: add/sub (wraparound), bitwise or, pass B; zero flag on the result.
// Purely combinational, no flow control.
module alu_decode_alu
  import alu_decode_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = a + b;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_OR:    result = a | b;
      ALU_PASSB: result = b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_decode_unit.sv
// MIPS-subset decode + ALU: fields/ext_op combinational, controls/result 1-cycle registered.
// No backpressure, accepts every cycle; ILLEGAL_FLAG_EN adds the registered illegal output.
module alu_decode_unit
  import alu_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] ext_imm,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [1:0]  ext_op,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        zero,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_op,
  output logic        branch_taken,
  output logic        dm_we,
  output logic        grf_we,
  output logic [4:0]  grf_waddr,
  output logic [1:0]  grf_data_sel,
  output logic        alu_src,
  output logic [31:0] wdata
`ifdef ILLEGAL_FLAG_EN
  ,
  output logic        illegal
`endif
);

  ctrl_t       ctrl_d;
  ctrl_t       ctrl_q;
  ext_op_e     ext_d;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [31:0] result_q;
  logic [31:0] wdata_q;
  logic        zero_q;
  logic        valid_q;
  logic        taken_q;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign imm26  = instr[25:0];
  assign ext_op = ext_d;

  // Unlisted encodings (including nop) fall through with the all-zero control word.
  always_comb begin
    ctrl_d = CTRL_NOP;
    ext_d  = EXT_ZERO;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            ctrl_d.grf_we    = 1'b1;
            ctrl_d.grf_waddr = rd;
          end
          FN_SUB: begin
            ctrl_d.alu_op    = ALU_SUB;
            ctrl_d.grf_we    = 1'b1;
            ctrl_d.grf_waddr = rd;
          end
          FN_JR:   ctrl_d.pc_op = PC_JR;
          default: ;
        endcase
      end
      OP_ORI: begin
        ctrl_d.alu_op    = ALU_OR;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.grf_we    = 1'b1;
        ctrl_d.grf_waddr = rt;
      end
      OP_LW: begin
        ext_d               = EXT_SIGN;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.grf_we       = 1'b1;
        ctrl_d.grf_waddr    = rt;
        ctrl_d.grf_data_sel = SEL_MEM;
      end
      OP_SW: begin
        ext_d          = EXT_SIGN;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.dm_we   = 1'b1;
      end
      OP_BEQ: begin
        ext_d         = EXT_SIGN;
        ctrl_d.alu_op = ALU_SUB;
        ctrl_d.pc_op  = PC_BEQ;
      end
      OP_LUI: begin
        ext_d            = EXT_LUI;
        ctrl_d.alu_op    = ALU_PASSB;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.grf_we    = 1'b1;
        ctrl_d.grf_waddr = rt;
      end
      OP_JAL: begin
        ctrl_d.pc_op        = PC_JAL;
        ctrl_d.grf_we       = 1'b1;
        ctrl_d.grf_waddr    = 5'd31;
        ctrl_d.grf_data_sel = SEL_PC4;
      end
      default: ;
    endcase
  end

  assign alu_b = ctrl_d.alu_src ? ext_imm : rt_val;

  alu_decode_alu u_alu (
    .op     (ctrl_d.alu_op),
    .a      (rs_val),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Stage loads regardless of in_valid; consumers qualify write enables with out_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q   <= CTRL_NOP;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      wdata_q  <= 32'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      result_q <= alu_res;
      zero_q   <= alu_zero;
      valid_q  <= in_valid;
      taken_q  <= (ctrl_d.pc_op == PC_BEQ) && alu_zero;
      wdata_q  <= rt_val;
    end
  end

`ifdef ILLEGAL_FLAG_EN
  always_ff @(posedge clk) begin
    if (!reset) illegal <= 1'b0;
    else        illegal <= in_valid && !is_known(instr) && (instr != 32'd0);
  end
`endif

  assign out_valid    = valid_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign alu_op       = ctrl_q.alu_op;
  assign pc_op        = ctrl_q.pc_op;
  assign branch_taken = taken_q;
  assign dm_we        = ctrl_q.dm_we;
  assign grf_we       = ctrl_q.grf_we;
  assign grf_waddr    = ctrl_q.grf_waddr;
  assign grf_data_sel = ctrl_q.grf_data_sel;
  assign alu_src      = ctrl_q.alu_src;
  assign wdata        = wdata_q;

endmodule

// File: tb/tb_alu_decode_unit.sv
// Directed-vector bench for alu_decode_unit with hand-computed expectations.
module tb_alu_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr, rs_val, rt_val, ext_imm;
  logic [4:0]  rs, rt, rd, grf_waddr;
  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [1:0]  ext_op, alu_op, pc_op, grf_data_sel;
  logic        out_valid, zero, branch_taken, dm_we, grf_we, alu_src;
  logic [31:0] result, wdata;
`ifdef ILLEGAL_FLAG_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_decode_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .ext_imm(ext_imm),
    .rs(rs), .rt(rt), .rd(rd), .opcode(opcode), .funct(funct),
    .imm16(imm16), .imm26(imm26), .ext_op(ext_op),
    .out_valid(out_valid), .result(result), .zero(zero),
    .alu_op(alu_op), .pc_op(pc_op), .branch_taken(branch_taken),
    .dm_we(dm_we), .grf_we(grf_we), .grf_waddr(grf_waddr),
    .grf_data_sel(grf_data_sel), .alu_src(alu_src), .wdata(wdata)
`ifdef ILLEGAL_FLAG_EN
    , .illegal(illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
    in_valid = v; instr = i; rs_val = a; rt_val = b; ext_imm = e;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_grf_we", grf_we, 0);
    check("rst_pc_op", pc_op, 0);

    reset = 1'b1;
    // add $3,$1,$2
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 32'd0);
    check("add_rs", rs, 1);
    check("add_rt", rt, 2);
    check("add_rd", rd, 3);
    check("add_opcode", opcode, 0);
    check("add_funct", funct, 32'h20);
    tick();
    check("add_valid", out_valid, 1);
    check("add_result", result, 12);
    check("add_zero", zero, 0);
    check("add_grf_we", grf_we, 1);
    check("add_waddr", grf_waddr, 3);
    check("add_sel", grf_data_sel, 0);
    check("add_alu_op", alu_op, 0);

    // ori $2,$1,0xFFFF
    drive(1'b1, 32'h3422_FFFF, 32'h1234_0000, 32'h0, 32'h0000_FFFF);
    check("ori_ext_op", ext_op, 0);
    check("ori_imm16", imm16, 32'hFFFF);
    tick();
    check("ori_result", result, 32'h1234_FFFF);
    check("ori_waddr", grf_waddr, 2);
    check("ori_alu_op", alu_op, 2);
    check("ori_alu_src", alu_src, 1);

    // beq taken, then not taken
    drive(1'b1, 32'h1022_0003, 32'hA5, 32'hA5, 32'h3);
    check("beq_ext_op", ext_op, 1);
    tick();
    check("beq_zero", zero, 1);
    check("beq_pc_op", pc_op, 1);
    check("beq_taken", branch_taken, 1);
    check("beq_grf_we", grf_we, 0);
    drive(1'b1, 32'h1022_0003, 32'hA5, 32'hA6, 32'h3);
    tick();
    check("beqn_result", result, 32'hFFFF_FFFF);
    check("beqn_zero", zero, 0);
    check("beqn_taken", branch_taken, 0);

    // lw then sw back-to-back
    drive(1'b1, 32'h8C22_0004, 32'h100, 32'h55, 32'h4);
    check("lw_ext_op", ext_op, 1);
    tick();
    check("lw_result", result, 32'h104);
    check("lw_sel", grf_data_sel, 1);
    check("lw_grf_we", grf_we, 1);
    check("lw_waddr", grf_waddr, 2);
    drive(1'b1, 32'hAC22_0004, 32'h100, 32'hDEAD_BEEF, 32'h4);
    tick();
    check("sw_result", result, 32'h104);
    check("sw_dm_we", dm_we, 1);
    check("sw_grf_we", grf_we, 0);
    check("sw_waddr", grf_waddr, 0);
    check("sw_wdata", wdata, 32'hDEAD_BEEF);

    // lui $1,0xABCD
    drive(1'b1, 32'h3C01_ABCD, 32'h1111_1111, 32'h0, 32'hABCD_0000);
    check("lui_ext_op", ext_op, 2);
    tick();
    check("lui_result", result, 32'hABCD_0000);
    check("lui_alu_op", alu_op, 3);
    check("lui_waddr", grf_waddr, 1);

    // jal, jr
    drive(1'b1, 32'h0C00_0C00, 32'h0, 32'h0, 32'h0);
    check("jal_imm26", imm26, 32'h0000_0C00);
    check("jal_ext_op", ext_op, 0);
    tick();
    check("jal_waddr", grf_waddr, 31);
    check("jal_sel", grf_data_sel, 2);
    check("jal_pc_op", pc_op, 2);
    check("jal_grf_we", grf_we, 1);
    drive(1'b1, 32'h03E0_0008, 32'h400, 32'h0, 32'h0);
    check("jr_rs", rs, 31);
    tick();
    check("jr_pc_op", pc_op, 3);
    check("jr_grf_we", grf_we, 0);

    // nop
    drive(1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("nop_grf_we", grf_we, 0);
    check("nop_pc_op", pc_op, 0);
    check("nop_valid", out_valid, 1);
`ifdef ILLEGAL_FLAG_EN
    check("nop_illegal", illegal, 0);
`endif

    // bubble: stage still loads, out_valid low
    drive(1'b0, 32'h0022_1820, 32'd1, 32'd2, 32'd0);
    tick();
    check("bub_valid", out_valid, 0);
    check("bub_result", result, 3);

    // illegal opcode 0x3F
    drive(1'b1, 32'hFC00_0000, 32'h1, 32'h2, 32'h0);
    check("ill_ext_op", ext_op, 0);
    tick();
    check("ill_grf_we", grf_we, 0);
    check("ill_dm_we", dm_we, 0);
    check("ill_pc_op", pc_op, 0);
    check("ill_alu_op", alu_op, 0);
    check("ill_valid", out_valid, 1);
`ifdef ILLEGAL_FLAG_EN
    check("ill_flag", illegal, 1);
    drive(1'b0, 32'hFC00_0000, 32'h1, 32'h2, 32'h0);
    tick();
    check("ill_flag_novalid", illegal, 0);
`endif

    // reset with add in flight
    drive(1'b1, 32'h0022_1820, 32'd5, 32'd7, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_grf_we", grf_we, 0);
    check("mid_rst_waddr", grf_waddr, 0);
    check("mid_rst_wdata", wdata, 0);
    reset = 1'b1;
    tick();
    check("post_rst_result", result, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
